// File: rtl/execute_fwd_ctrl.sv
// Execute-stage controller: holds the decoded instruction, picks operand sources from
// NUM_FWD younger-stage result buses (youngest first) and interlocks on load-use hazards.
module execute_fwd_ctrl #(
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = $clog2(NUM_FWD + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [3:0]           cond_in,
  input  logic [6:0]           opcode_in,
  input  logic [3:0]           rn_in,
  input  logic [3:0]           rs_in,
  input  logic [3:0]           rm_in,
  input  logic [4:0]           imm5_in,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic [4*NUM_FWD-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]   fwd_valid,
  input  logic [NUM_FWD-1:0]   fwd_is_load,
  output logic                 out_valid,
  output logic [6:0]           opcode,
  output logic [3:0]           rn,
  output logic [3:0]           rs,
  output logic [3:0]           rm,
  output logic [4:0]           imm5,
  output logic [SEL_W-1:0]     sel_A_in,
  output logic [SEL_W-1:0]     sel_B_in,
  output logic [SEL_W-1:0]     sel_shift_in,
  output logic                 sel_shift,
  output logic                 en_A,
  output logic                 en_B,
  output logic                 en_S,
  output logic                 stall_req
);

  localparam int unsigned CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  // The detecting RUN cycle is the first bubble, so INTERLOCK covers the remaining LOAD_LAT-1.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);
  localparam logic [SEL_W-1:0] SEL_RF = '0;
  localparam logic [SEL_W-1:0] SEL_PC = '1;

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_INTERLOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;
  logic [3:0]       cond_q;

  logic is_alu, is_mem, is_br;
  logic use_rn, use_rm, use_rs;
  logic a_pc, s_pc;
  logic dec_en_a, dec_en_b, dec_en_s, dec_sel_shift;
  logic hazard;

  // Lowest-index (youngest) matching source wins; r15 and an in-flight load at source 0 never forward.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic [3:0]           r,
    input logic [4*NUM_FWD-1:0] frd,
    input logic [NUM_FWD-1:0]   fv,
    input logic                 ld0
  );
    logic [SEL_W-1:0] s;
    s = SEL_RF;
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      if (fv[k] && (frd[4*k +: 4] == r) && (r != 4'hF) && !((k == 0) && ld0))
        s = SEL_W'(k + 1);
    end
    return s;
  endfunction

  function automatic logic src0_match(
    input logic [3:0] r,
    input logic [3:0] rd0,
    input logic       v0
  );
    return v0 && (rd0 == r) && (r != 4'hF);
  endfunction

  if (NUM_FWD > 1) begin : g_unused_load
    logic unused_load_bits;
    assign unused_load_bits = ^fwd_is_load[NUM_FWD-1:1];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      cond_q  <= '0;
      opcode  <= '0;
      rn      <= '0;
      rs      <= '0;
      rm      <= '0;
      imm5    <= '0;
    end else if (flush_in) begin
      valid_q <= 1'b0;
    end else if (!stall_in && !stall_req) begin
      valid_q <= in_valid;
      if (in_valid) begin
        cond_q <= cond_in;
        opcode <= opcode_in;
        rn     <= rn_in;
        rs     <= rs_in;
        rm     <= rm_in;
        imm5   <= imm5_in;
      end
    end
  end

  // Decode, forwarding, interlock next-state and outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    use_rn        = 1'b0;
    use_rm        = 1'b0;
    use_rs        = 1'b0;
    a_pc          = 1'b0;
    s_pc          = 1'b0;
    dec_en_a      = 1'b0;
    dec_en_b      = 1'b0;
    dec_en_s      = 1'b0;
    dec_sel_shift = 1'b0;
    out_valid     = 1'b0;
    stall_req     = 1'b0;
    sel_A_in      = SEL_RF;
    sel_B_in      = SEL_RF;
    sel_shift_in  = SEL_RF;
    sel_shift     = 1'b0;
    en_A          = 1'b0;
    en_B          = 1'b0;
    en_S          = 1'b0;

    is_alu = !opcode[6] && (cond_q != 4'hF);
    is_mem = (opcode[6:5] == 2'b11) || (opcode[6:3] == 4'b1000);
    is_br  = (opcode[6:4] == 3'b101);

    if (is_alu) begin
      use_rn        = 1'b1;
      use_rm        = 1'b1;
      use_rs        = opcode[4];
      dec_en_a      = opcode[3];
      dec_en_b      = opcode[4];
      dec_en_s      = 1'b1;
      dec_sel_shift = opcode[4] & opcode[5];
    end else if (is_mem) begin
      if (!opcode[3]) begin
        dec_en_a = 1'b1;
        a_pc     = (opcode[6:4] == 3'b100);
      end else begin
        use_rn   = 1'b1;
        use_rm   = 1'b1;
        dec_en_a = 1'b1;
        dec_en_b = 1'b1;
        dec_en_s = 1'b1;
      end
    end else if (is_br) begin
      use_rm        = opcode[1];
      dec_en_b      = opcode[1];
      dec_en_s      = 1'b1;
      dec_sel_shift = 1'b1;
      s_pc          = 1'b1;
    end

    hazard = !rst && valid_q && (state_q == ST_RUN) && fwd_is_load[0] &&
             ((use_rn && src0_match(rn, fwd_rd[3:0], fwd_valid[0])) ||
              (use_rm && src0_match(rm, fwd_rd[3:0], fwd_valid[0])) ||
              (use_rs && src0_match(rs, fwd_rd[3:0], fwd_valid[0])));

    out_valid = !rst && valid_q && (state_q == ST_RUN) && !hazard;
    stall_req = !rst && ((state_q == ST_INTERLOCK) || hazard);

    if (out_valid) begin
      if (a_pc)        sel_A_in = SEL_PC;
      else if (use_rn) sel_A_in = fwd_sel(rn, fwd_rd, fwd_valid, fwd_is_load[0]);
      if (use_rm)      sel_B_in = fwd_sel(rm, fwd_rd, fwd_valid, fwd_is_load[0]);
      if (s_pc)        sel_shift_in = SEL_PC;
      else if (use_rs) sel_shift_in = fwd_sel(rs, fwd_rd, fwd_valid, fwd_is_load[0]);
      sel_shift = dec_sel_shift;
      en_A      = dec_en_a;
      en_B      = dec_en_b;
      en_S      = dec_en_s;
    end

    if (flush_in) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (!stall_in) begin
      case (state_q)
        ST_RUN: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_d = ST_INTERLOCK;
            cnt_d   = CNT_INIT;
          end
        end
        ST_INTERLOCK: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_fwd_ctrl.sv
// Directed bench for execute_fwd_ctrl: one instance with LOAD_LAT=1 and one with LOAD_LAT=2.
module tb_execute_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] cond_in;
  logic [6:0] opcode_in;
  logic [3:0] rn_in, rs_in, rm_in;
  logic [4:0] imm5_in;
  logic       stall_in, flush_in;
  logic [7:0] fwd_rd;
  logic [1:0] fwd_valid, fwd_is_load;

  logic       ov1, ss1, ea1, eb1, es1, sr1;
  logic [6:0] op1;
  logic [3:0] rn1, rs1, rm1;
  logic [4:0] im1;
  logic [1:0] sa1, sb1, sh1;

  logic       ov2, ss2, ea2, eb2, es2, sr2;
  logic [6:0] op2;
  logic [3:0] rn2, rs2, rm2;
  logic [4:0] im2;
  logic [1:0] sa2, sb2, sh2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_fwd_ctrl #(.NUM_FWD(2), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cond_in(cond_in), .opcode_in(opcode_in),
    .rn_in(rn_in), .rs_in(rs_in), .rm_in(rm_in), .imm5_in(imm5_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .fwd_rd(fwd_rd), .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
    .out_valid(ov1), .opcode(op1), .rn(rn1), .rs(rs1), .rm(rm1), .imm5(im1),
    .sel_A_in(sa1), .sel_B_in(sb1), .sel_shift_in(sh1), .sel_shift(ss1),
    .en_A(ea1), .en_B(eb1), .en_S(es1), .stall_req(sr1)
  );

  execute_fwd_ctrl #(.NUM_FWD(2), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cond_in(cond_in), .opcode_in(opcode_in),
    .rn_in(rn_in), .rs_in(rs_in), .rm_in(rm_in), .imm5_in(imm5_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .fwd_rd(fwd_rd), .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
    .out_valid(ov2), .opcode(op2), .rn(rn2), .rs(rs2), .rm(rm2), .imm5(im2),
    .sel_A_in(sa2), .sel_B_in(sb2), .sel_shift_in(sh2), .sel_shift(ss2),
    .en_A(ea2), .en_B(eb2), .en_S(es2), .stall_req(sr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [3:0] c, input logic [6:0] op,
                         input logic [3:0] n, input logic [3:0] s, input logic [3:0] m);
    in_valid  = v;
    cond_in   = c;
    opcode_in = op;
    rn_in     = n;
    rs_in     = s;
    rm_in     = m;
  endtask

  task automatic fwd(input logic [3:0] rd1, input logic [3:0] rd0,
                     input logic [1:0] v, input logic [1:0] ld);
    fwd_rd      = {rd1, rd0};
    fwd_valid   = v;
    fwd_is_load = ld;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; imm5_in = 5'd5;
    present(1'b1, 4'hE, 7'b0001000, 4'd3, 4'd0, 4'd4);
    fwd(4'd0, 4'd0, 2'b00, 2'b00);
    cyc(); cyc();
    #2;
    chk("reset_out_valid", 32'(ov1), 0);
    chk("reset_opcode",    32'(op1), 0);
    chk("reset_en_S",      32'(es1), 0);
    chk("reset_stall_req", 32'(sr1), 0);

    // Instruction A: ALU add rn=3 rm=4, both sources forward
    rst = 1'b0;
    #2;
    chk("post_reset_out_valid", 32'(ov1), 0);
    chk("post_reset_en_A",      32'(ea1), 0);
    cyc();
    fwd(4'd4, 4'd3, 2'b11, 2'b00);
    present(1'b1, 4'hE, 7'b0001000, 4'd5, 4'd0, 4'd7);
    #2;
    chk("alu_out_valid", 32'(ov1), 1);
    chk("alu_sel_A",     32'(sa1), 1);
    chk("alu_sel_B",     32'(sb1), 2);
    chk("alu_sel_shift_in", 32'(sh1), 0);
    chk("alu_en_A",      32'(ea1), 1);
    chk("alu_en_B",      32'(eb1), 0);
    chk("alu_en_S",      32'(es1), 1);
    chk("alu_imm5",      32'(im1), 5);
    chk("alu_stall_req", 32'(sr1), 0);

    // Instruction B: rn=5 matches both sources -> youngest
    cyc();
    fwd(4'd5, 4'd5, 2'b11, 2'b00);
    present(1'b1, 4'hE, 7'b0001000, 4'd15, 4'd0, 4'd5);
    #2;
    chk("youngest_sel_A", 32'(sa1), 1);
    chk("nomatch_sel_B",  32'(sb1), 0);
    chk("b_rn",           32'(rn1), 5);

    // Instruction C: rn=15 never forwarded
    cyc();
    fwd(4'd5, 4'd15, 2'b11, 2'b00);
    present(1'b1, 4'hE, 7'b0111000, 4'd1, 4'd6, 4'd2);
    #2;
    chk("r15_sel_A", 32'(sa1), 0);
    chk("c_sel_B",   32'(sb1), 2);

    // Instruction D: shift-by-register ALU, load flag on source 1 is irrelevant
    cyc();
    fwd(4'd2, 4'd6, 2'b11, 2'b10);
    present(1'b1, 4'hE, 7'b0001000, 4'd9, 4'd0, 4'd2);
    #2;
    chk("d_sel_A",        32'(sa1), 0);
    chk("d_sel_B",        32'(sb1), 2);
    chk("d_sel_shift_in", 32'(sh1), 1);
    chk("d_sel_shift",    32'(ss1), 1);
    chk("d_en_B",         32'(eb1), 1);

    // Instruction E: load-use on rm=2 with LOAD_LAT=1
    cyc();
    fwd(4'd0, 4'd2, 2'b01, 2'b01);
    present(1'b1, 4'hE, 7'b1010010, 4'd0, 4'd0, 4'd8);
    #2;
    chk("lu1_stall_req", 32'(sr1), 1);
    chk("lu1_out_valid", 32'(ov1), 0);
    chk("lu1_en_S",      32'(es1), 0);
    cyc();
    fwd(4'd2, 4'd0, 2'b10, 2'b00);
    #2;
    chk("lu1_after_out_valid", 32'(ov1), 1);
    chk("lu1_after_stall_req", 32'(sr1), 0);
    chk("lu1_after_sel_B",     32'(sb1), 2);
    chk("lu1_after_rm",        32'(rm1), 2);
    chk("lu1_after_rn",        32'(rn1), 9);

    // Instruction F: branch with register offset
    cyc();
    fwd(4'd0, 4'd8, 2'b01, 2'b00);
    present(1'b1, 4'hE, 7'b1000000, 4'd3, 4'd0, 4'd0);
    #2;
    chk("br_sel_B",        32'(sb1), 1);
    chk("br_sel_A",        32'(sa1), 0);
    chk("br_sel_shift_in", 32'(sh1), 3);
    chk("br_sel_shift",    32'(ss1), 1);
    chk("br_en_B",         32'(eb1), 1);
    chk("br_en_A",         32'(ea1), 0);

    // Instruction G: LDR literal -> PC on A
    cyc();
    fwd(4'd0, 4'd3, 2'b01, 2'b00);
    present(1'b1, 4'hF, 7'b0001000, 4'd3, 4'd0, 4'd4);
    #2;
    chk("ldr_sel_A", 32'(sa1), 3);
    chk("ldr_en_A",  32'(ea1), 1);
    chk("ldr_en_B",  32'(eb1), 0);
    chk("ldr_en_S",  32'(es1), 0);

    // Instruction H: cond=F on ALU opcode decodes as other
    cyc();
    present(1'b0, 4'hE, 7'b0000000, 4'd0, 4'd0, 4'd0);
    #2;
    chk("other_out_valid", 32'(ov1), 1);
    chk("other_en_S",      32'(es1), 0);
    chk("other_sel_A",     32'(sa1), 0);
    cyc();
    #2;
    chk("idle_out_valid", 32'(ov1), 0);

    // LOAD_LAT=2 with a 3-cycle downstream stall mid-interlock
    rst = 1'b1;
    fwd(4'd0, 4'd0, 2'b00, 2'b00);
    cyc();
    rst = 1'b0;
    present(1'b1, 4'hE, 7'b0001000, 4'd9, 4'd0, 4'd2);
    cyc();
    cyc();
    fwd(4'd0, 4'd2, 2'b01, 2'b01);
    #2;
    chk("lu2_detect_stall_req", 32'(sr2), 1);
    chk("lu2_detect_out_valid", 32'(ov2), 0);
    cyc();
    fwd(4'd2, 4'd0, 2'b10, 2'b00);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lu2_stall_out_valid", 32'(ov2), 0);
      chk("lu2_stall_stall_req", 32'(sr2), 1);
      chk("lu2_stall_rm",        32'(rm2), 2);
      cyc();
    end
    stall_in = 1'b0;
    #2;
    chk("lu2_last_bubble_out_valid", 32'(ov2), 0);
    chk("lu2_last_bubble_stall_req", 32'(sr2), 1);
    cyc();
    #2;
    chk("lu2_resume_out_valid", 32'(ov2), 1);
    chk("lu2_resume_stall_req", 32'(sr2), 0);
    chk("lu2_resume_sel_B",     32'(sb2), 2);
    chk("lu2_resume_rn",        32'(rn2), 9);

    // Flush together with stall while interlocked
    cyc();
    fwd(4'd0, 4'd2, 2'b01, 2'b01);
    #2;
    chk("fl_detect_stall_req", 32'(sr2), 1);
    cyc();
    stall_in = 1'b1;
    flush_in = 1'b1;
    #2;
    chk("fl_interlock_stall_req", 32'(sr2), 1);
    chk("fl_interlock_out_valid", 32'(ov2), 0);
    cyc();
    stall_in = 1'b0;
    flush_in = 1'b0;
    present(1'b1, 4'hE, 7'b0001000, 4'd3, 4'd0, 4'd4);
    #2;
    chk("fl_after_out_valid", 32'(ov2), 0);
    chk("fl_after_stall_req", 32'(sr2), 0);
    cyc();
    present(1'b0, 4'hE, 7'b0000000, 4'd0, 4'd0, 4'd0);
    #2;
    chk("fl_run_out_valid", 32'(ov2), 1);
    chk("fl_run_rn",        32'(rn2), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
